// File: rtl/m_stage_mem_access_pkg.sv
// +----------------------------------------------------------------------+
// | m_stage_mem_access_pkg : memop opcodes, exception codes, FSM states  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package m_stage_mem_access_pkg;

  localparam logic [5:0] OPC_LB  = 6'h20;
  localparam logic [5:0] OPC_LH  = 6'h21;
  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_LBU = 6'h24;
  localparam logic [5:0] OPC_LHU = 6'h25;
  localparam logic [5:0] OPC_SB  = 6'h28;
  localparam logic [5:0] OPC_SH  = 6'h29;
  localparam logic [5:0] OPC_SW  = 6'h2B;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DEF_DM_SIZE     = 32'h0000_3000;
  localparam logic [31:0] DEF_DEV_T0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEF_DEV_T1_BASE = 32'h0000_7F10;
  localparam logic [31:0] DEF_DEV_IG_BASE = 32'h0000_7F20;
  localparam logic [31:0] TIMER_WIN       = 32'd12;
  localparam logic [31:0] IG_WIN          = 32'd4;
  localparam logic [31:0] TIMER_COUNT_OFS = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mstate_e;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_e;

  function automatic mem_op_e decode_memop(input logic [5:0] opc);
    mem_op_e op;
    case (opc)
      OPC_LB:  op = MOP_LB;
      OPC_LBU: op = MOP_LBU;
      OPC_LH:  op = MOP_LH;
      OPC_LHU: op = MOP_LHU;
      OPC_LW:  op = MOP_LW;
      OPC_SB:  op = MOP_SB;
      OPC_SH:  op = MOP_SH;
      OPC_SW:  op = MOP_SW;
      default: op = MOP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_store_op(input mem_op_e op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_mem_align.sv
// +----------------------------------------------------------------------+
// | m_mem_align : address legality, store lane formatting, load extend   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module m_mem_align
  import m_stage_mem_access_pkg::*;
#(
  parameter logic [31:0] DM_SIZE     = DEF_DM_SIZE,
  parameter logic [31:0] DEV_T0_BASE = DEF_DEV_T0_BASE,
  parameter logic [31:0] DEV_T1_BASE = DEF_DEV_T1_BASE,
  parameter logic [31:0] DEV_IG_BASE = DEF_DEV_IG_BASE
) (
  input  mem_op_e     op,
  input  logic [31:0] addr,
  input  logic [31:0] rt,
  input  mem_op_e     ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic [31:0] ld_ext
);

  logic        is_word, is_half, is_store, aligned;
  logic        in_ram, in_t0, in_t1, in_ig, in_dev, cnt_store;
  logic [31:0] t0_off, t1_off, ig_off;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    is_word  = (op == MOP_LW) || (op == MOP_SW);
    is_half  = (op == MOP_LH) || (op == MOP_LHU) || (op == MOP_SH);
    is_store = is_store_op(op);
    aligned  = is_word ? (addr[1:0] == 2'b00) : (is_half ? !addr[0] : 1'b1);

    // Offsets wrap below the base, so one unsigned compare bounds each window.
    t0_off    = addr - DEV_T0_BASE;
    t1_off    = addr - DEV_T1_BASE;
    ig_off    = addr - DEV_IG_BASE;
    in_ram    = addr < DM_SIZE;
    in_t0     = t0_off < TIMER_WIN;
    in_t1     = t1_off < TIMER_WIN;
    in_ig     = ig_off < IG_WIN;
    in_dev    = in_t0 || in_t1 || in_ig;
    cnt_store = is_store && ((in_t0 && (t0_off == TIMER_COUNT_OFS)) ||
                             (in_t1 && (t1_off == TIMER_COUNT_OFS)));

    legal = (op != MOP_NONE) && aligned && !cnt_store &&
            (in_ram || (in_dev && is_word));

    byteen = 4'b1111;
    wdata  = 32'd0;
    case (op)
      MOP_SW: wdata = rt;
      MOP_SH: begin
        wdata  = {2{rt[15:0]}};
        byteen = addr[1] ? 4'b1100 : 4'b0011;
      end
      MOP_SB: begin
        wdata  = {4{rt[7:0]}};
        byteen = 4'b0001 << addr[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_lo)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = ld_lo[1] ? rdata[31:16] : rdata[15:0];

    case (ld_op)
      MOP_LB:  ld_ext = {{24{sel_byte[7]}}, sel_byte};
      MOP_LBU: ld_ext = {24'd0, sel_byte};
      MOP_LH:  ld_ext = {{16{sel_half[15]}}, sel_half};
      MOP_LHU: ld_ext = {16'd0, sel_half};
      MOP_LW:  ld_ext = rdata;
      default: ld_ext = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/m_stage_mem_access.sv
// +----------------------------------------------------------------------+
// | m_stage_mem_access : M-stage load/store unit with req/ack data bus   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module m_stage_mem_access
  import m_stage_mem_access_pkg::*;
#(
  parameter logic [31:0] DM_SIZE     = DEF_DM_SIZE,
  parameter logic [31:0] DEV_T0_BASE = DEF_DEV_T0_BASE,
  parameter logic [31:0] DEV_T1_BASE = DEF_DEV_T1_BASE,
  parameter logic [31:0] DEV_IG_BASE = DEF_DEV_IG_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_rt,
  input  logic        m_flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc
);

  mstate_e     state_q, state_d;
  mem_op_e     op_q, op_d, cur_op;
  logic [1:0]  lo_q, lo_d;
  logic        cancel_q, cancel_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_byteen_q, bus_byteen_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic        al_legal;
  logic [3:0]  al_byteen;
  logic [31:0] al_wdata, al_ld_ext;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^m_instr[25:0];
  assign cur_op            = m_valid ? decode_memop(m_instr[31:26]) : MOP_NONE;

  // Extension uses the op latched on REQ entry, not the live M register.
  m_mem_align #(
    .DM_SIZE    (DM_SIZE),
    .DEV_T0_BASE(DEV_T0_BASE),
    .DEV_T1_BASE(DEV_T1_BASE),
    .DEV_IG_BASE(DEV_IG_BASE)
  ) u_align (
    .op    (cur_op),
    .addr  (m_addr),
    .rt    (m_rt),
    .ld_op (op_q),
    .ld_lo (lo_q),
    .rdata (bus_rdata),
    .legal (al_legal),
    .byteen(al_byteen),
    .wdata (al_wdata),
    .ld_ext(al_ld_ext)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lo_d         = lo_q;
    cancel_d     = cancel_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_byteen_d = bus_byteen_q;
    bus_wdata_d  = bus_wdata_q;
    ld_data_d    = ld_data_q;
    bus_req      = 1'b0;
    stall        = 1'b0;
    ld_valid     = 1'b0;
    exc          = 1'b0;
    exc_code     = EXC_NONE;
    exc_pc       = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (!m_flush && (cur_op != MOP_NONE)) begin
          if (al_legal) begin
            stall        = 1'b1;
            state_d      = ST_REQ;
            op_d         = cur_op;
            lo_d         = m_addr[1:0];
            cancel_d     = 1'b0;
            bus_we_d     = is_store_op(cur_op);
            bus_addr_d   = {m_addr[31:2], 2'b00};
            bus_byteen_d = al_byteen;
            bus_wdata_d  = al_wdata;
          end else begin
            exc      = 1'b1;
            exc_code = is_store_op(cur_op) ? EXC_ADES : EXC_ADEL;
            exc_pc   = m_pc;
          end
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (m_flush) cancel_d = 1'b1;
        if (bus_ack) begin
          ld_data_d = al_ld_ext;
          // A cancelled transfer finishes silently and releases the pipe now.
          if (cancel_q || m_flush) begin
            stall    = 1'b0;
            cancel_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        ld_valid = !is_store_op(op_q) && !m_flush;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= MOP_NONE;
      lo_q         <= 2'b00;
      cancel_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_byteen_q <= 4'd0;
      bus_wdata_q  <= 32'd0;
      ld_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lo_q         <= lo_d;
      cancel_q     <= cancel_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_byteen_q <= bus_byteen_d;
      bus_wdata_q  <= bus_wdata_d;
      ld_data_q    <= ld_data_d;
    end
  end

  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_byteen = bus_byteen_q;
  assign bus_wdata  = bus_wdata_q;
  assign ld_data    = ld_data_q;

endmodule

`default_nettype wire

// File: tb/tb_m_stage_mem_access.sv
// +----------------------------------------------------------------------+
// | tb_m_stage_mem_access : randomized bench with transaction-level model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_m_stage_mem_access;

  logic        clk, reset;
  logic        m_valid, m_flush;
  logic [31:0] m_instr, m_pc, m_addr, m_rt;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;
  logic        stall, ld_valid, exc;
  logic [31:0] ld_data, exc_pc;
  logic [4:0]  exc_code;

  m_stage_mem_access dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_instr(m_instr), .m_pc(m_pc),
    .m_addr(m_addr), .m_rt(m_rt), .m_flush(m_flush), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .exc(exc), .exc_code(exc_code), .exc_pc(exc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_en = 1'b0, chk_zero = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_ldv, exp_exc;
  logic [31:0] exp_addr, exp_wd, exp_ldd, exp_pc;
  logic [3:0]  exp_be;
  logic [4:0]  exp_code;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // ---------------- reference model (address arithmetic) ----------------
  function automatic int acc_size(input logic [5:0] opc);
    if (opc == 6'h23 || opc == 6'h2B) return 4;
    if (opc == 6'h21 || opc == 6'h25 || opc == 6'h29) return 2;
    return 1;
  endfunction

  function automatic bit is_mem(input logic [5:0] opc);
    return opc inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic bit is_st(input logic [5:0] opc);
    return opc inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic bit m_legal(input logic [5:0] opc, input logic [31:0] a);
    int sz = acc_size(opc);
    if ((a % sz) != 0) return 0;
    if (a < 32'h3000) return 1;
    if ((a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C) ||
        (a >= 32'h7F20 && a < 32'h7F24)) begin
      if (sz != 4) return 0;
      if (is_st(opc) && (a == 32'h7F08 || a == 32'h7F18)) return 0;
      return 1;
    end
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] opc, input logic [31:0] a);
    if (!is_st(opc) || acc_size(opc) == 4) return 4'hF;
    if (acc_size(opc) == 2) return 4'(4'b0011 << (a % 4));
    return 4'(4'b0001 << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [5:0] opc, input logic [31:0] rt);
    if (!is_st(opc)) return 32'd0;
    if (acc_size(opc) == 4) return rt;
    if (acc_size(opc) == 2) return (rt & 32'hFFFF) * 32'h0001_0001;
    return (rt & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_ext(input logic [5:0] opc, input logic [31:0] a,
                                        input logic [31:0] rd);
    logic [31:0] v = rd >> ((a % 4) * 8);
    case (opc)
      6'h20:   return (v[7] ? 32'hFFFF_FF00 : 32'd0) | (v & 32'hFF);
      6'h24:   return v & 32'hFF;
      6'h21:   return (v[15] ? 32'hFFFF_0000 : 32'd0) | (v & 32'hFFFF);
      6'h25:   return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", 32'(stall), 32'(exp_stall));
      cmp("bus_req", 32'(bus_req), 32'(exp_req));
      cmp("ld_valid", 32'(ld_valid), 32'(exp_ldv));
      cmp("exc", 32'(exc), 32'(exp_exc));
      cmp("exc_code", 32'(exc_code), 32'(exp_code));
      cmp("exc_pc", exc_pc, exp_pc);
      if (exp_req) begin
        cmp("bus_we", 32'(bus_we), 32'(exp_we));
        cmp("bus_addr", bus_addr, exp_addr);
        cmp("bus_byteen", 32'(bus_byteen), 32'(exp_be));
        cmp("bus_wdata", bus_wdata, exp_wd);
      end
      if (exp_ldv) cmp("ld_data", ld_data, exp_ldd);
      if (chk_zero) begin
        cmp("rst_bus_we", 32'(bus_we), 32'd0);
        cmp("rst_bus_addr", bus_addr, 32'd0);
        cmp("rst_bus_byteen", 32'(bus_byteen), 32'd0);
        cmp("rst_bus_wdata", bus_wdata, 32'd0);
        cmp("rst_ld_data", ld_data, 32'd0);
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp;
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_ldv = 0; exp_exc = 0;
    exp_addr = 0; exp_wd = 0; exp_ldd = 0; exp_pc = 0; exp_be = 0; exp_code = 0;
  endtask

  task automatic bubble;
    m_valid = 0; m_flush = 0; bus_ack = 0; bus_rdata = $urandom;
    clear_exp();
    next_cycle();
  endtask

  // flush_at: -1 none, 0 in IDLE, k>=1 in k-th REQ cycle, 100 in DONE
  task automatic do_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] rt,
                       input logic [31:0] rd, input int nwait, input int flush_at);
    bit mem = is_mem(opc);
    bit st  = is_st(opc);
    bit lg  = mem && m_legal(opc, a);
    bit cancel = 0;
    m_valid   = 1;
    m_instr   = {opc, 26'($urandom)};
    m_addr    = a;
    m_rt      = rt;
    m_pc      = $urandom & 32'hFFFF_FFFC;
    m_flush   = (flush_at == 0);
    bus_ack   = 0;
    bus_rdata = $urandom;
    clear_exp();
    if (mem && flush_at != 0) begin
      if (lg) exp_stall = 1;
      else begin
        exp_exc  = 1;
        exp_code = st ? 5'd5 : 5'd4;
        exp_pc   = m_pc;
      end
    end
    next_cycle();
    if (!lg || flush_at == 0) begin
      m_flush = 0;
      return;
    end
    for (int i = 0; i <= nwait; i++) begin
      m_flush   = (flush_at == i + 1);
      cancel    = cancel | m_flush;
      bus_ack   = (i == nwait);
      bus_rdata = bus_ack ? rd : $urandom;
      clear_exp();
      exp_req   = 1;
      exp_we    = st;
      exp_addr  = a & 32'hFFFF_FFFC;
      exp_be    = m_be(opc, a);
      exp_wd    = m_wd(opc, rt);
      exp_stall = !(bus_ack && cancel);
      next_cycle();
    end
    bus_ack = 0;
    m_flush = 0;
    if (cancel) return;
    m_flush   = (flush_at == 100);
    bus_rdata = $urandom;
    clear_exp();
    exp_ldv = !st && (flush_at != 100);
    exp_ldd = m_ext(opc, a, rd);
    next_cycle();
    m_flush = 0;
  endtask

  initial begin
    logic [5:0]  opc;
    logic [31:0] a;
    int          nw, fa, r;
    logic [5:0]  memops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    reset = 1; m_valid = 0; m_flush = 0; m_instr = 0; m_pc = 0; m_addr = 0; m_rt = 0;
    bus_ack = 0; bus_rdata = 0;
    clear_exp();

    // pin the model with hand-computed values
    cmp("pin_lb", m_ext(6'h20, 32'h103, 32'h80FF_7F01), 32'hFFFF_FF80);
    cmp("pin_lbu", m_ext(6'h24, 32'h103, 32'h80FF_7F01), 32'h0000_0080);
    cmp("pin_lh", m_ext(6'h21, 32'h102, 32'h80FF_7F01), 32'hFFFF_80FF);
    cmp("pin_sh_be", 32'(m_be(6'h29, 32'h102)), 32'hC);
    cmp("pin_sh_wd", m_wd(6'h29, 32'h0000_1234), 32'h1234_1234);
    cmp("pin_sb_be", 32'(m_be(6'h28, 32'h101)), 32'h2);
    cmp("pin_sw_cnt", 32'(m_legal(6'h2B, 32'h7F08)), 32'd0);
    cmp("pin_lw_cnt", 32'(m_legal(6'h23, 32'h7F08)), 32'd1);
    cmp("pin_sb_dev", 32'(m_legal(6'h28, 32'h7F00)), 32'd0);
    cmp("pin_lw_top", 32'(m_legal(6'h23, 32'h3000)), 32'd0);
    cmp("pin_lh_odd", 32'(m_legal(6'h21, 32'h101)), 32'd0);

    repeat (3) next_cycle();
    reset = 0;
    chk_en = 1; chk_zero = 1;
    next_cycle();
    chk_zero = 0;

    // directed scenarios
    do_op(6'h2B, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, -1);
    do_op(6'h20, 32'h103, 32'h0, 32'h80FF_7F01, 3, -1);
    do_op(6'h24, 32'h103, 32'h0, 32'h80FF_7F01, 1, -1);
    do_op(6'h29, 32'h102, 32'h0000_1234, 32'h0, 0, -1);
    do_op(6'h21, 32'h101, 32'h0, 32'h0, 0, -1);
    do_op(6'h2B, 32'h7F08, 32'h5, 32'h0, 0, -1);
    do_op(6'h23, 32'h7F08, 32'h0, 32'h1234_5678, 0, -1);
    do_op(6'h28, 32'h7F00, 32'h5, 32'h0, 0, -1);
    do_op(6'h23, 32'h3000, 32'h0, 32'h0, 0, -1);
    do_op(6'h23, 32'h40, 32'h0, 32'hCAFE_F00D, 2, 1);
    bubble();
    do_op(6'h23, 32'h44, 32'h0, 32'h1111_2222, 0, 0);
    do_op(6'h23, 32'h48, 32'h0, 32'h3333_4444, 1, 100);
    bubble();

    // reset in the middle of an outstanding request
    do_op(6'h00, 32'h0, 32'h0, 32'h0, 0, -1);
    m_valid = 1; m_instr = {6'h23, 26'd0}; m_addr = 32'h200; m_flush = 0; bus_ack = 0;
    clear_exp(); exp_stall = 1;
    next_cycle();
    clear_exp(); exp_req = 1; exp_addr = 32'h200; exp_be = 4'hF; exp_stall = 1;
    next_cycle();
    chk_en = 0; reset = 1; m_valid = 0;
    next_cycle();
    reset = 0; chk_en = 1; chk_zero = 1;
    clear_exp();
    next_cycle();
    chk_zero = 0;
    do_op(6'h23, 32'h204, 32'h0, 32'hA5A5_5A5A, 1, -1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 8) opc = memops[$urandom_range(0, 7)];
      else begin
        opc = 6'($urandom);
        while (is_mem(opc)) opc = 6'($urandom);
      end
      r = $urandom_range(0, 5);
      case (r)
        0: a = $urandom_range(0, 32'h2FFF);
        1: a = 32'h2FF0 + $urandom_range(0, 31);
        2: a = 32'h7F00 + $urandom_range(0, 47);
        3: a = $urandom;
        4: a = $urandom_range(0, 32'h2FFF) & 32'hFFFF_FFFC;
        default: a = 32'h7EF8 + $urandom_range(0, 15);
      endcase
      nw = $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      if (r == 0) fa = 0;
      else if (r == 1) fa = $urandom_range(1, nw + 1);
      else if (r == 2) fa = 100;
      else fa = -1;
      do_op(opc, a, $urandom, $urandom, nw, fa);
      if ($urandom_range(0, 4) == 0) bubble();
    end
    bubble();
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
